// File: rtl/invaders_pkg.sv
// invaders_pkg: march states and speed constants shared by the invader march and motion blocks.
package invaders_pkg;
  typedef enum logic [2:0] {
    MARCH_R   = 3'd0,
    DESCEND_R = 3'd1,
    MARCH_L   = 3'd2,
    DESCEND_L = 3'd3,
    HALT      = 3'd4
  } march_state_t;
  localparam int MULTIPLIER = 64;
  localparam int SPEED_W    = 11;
endpackage

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable down-counter stepped by frame ticks, done while it holds 1.
module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == W'(1);
endmodule

// File: rtl/invader_march_ctrl.sv
// invader_march_ctrl: frame-tick march sequencer driving signed formation X/Y speeds.
// Define INVADER_CTRL_SPEEDUP_EN to enable speedUp stepping of the march magnitude.
module invader_march_ctrl
  import invaders_pkg::*;
#(
  parameter int INITIAL_X_SPEED = 30,
  parameter int Y_DESCEND_SPEED = 48,
  parameter int DESCEND_FRAMES  = 8,
  parameter int SPEED_STEP      = 4,
  parameter int MAX_SPEED       = 120
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      hitLeft,
  input  logic                      hitRight,
  input  logic                      reachedBottom,
  input  logic                      speedUp,
  input  logic                      restart,
  output logic signed [SPEED_W-1:0] xSpeed,
  output logic signed [SPEED_W-1:0] ySpeed,
  output logic                      chgDir,
  output logic                      gameOver,
  output logic [2:0]                marchState
);
  march_state_t       r_state, w_state_nxt;
  logic [9:0]         r_mag, w_mag_nxt;
  logic [SPEED_W-1:0] w_mag_ext, w_x_nxt;
  logic               w_load, w_done, w_descending;

  assign w_descending = r_state == DESCEND_R || r_state == DESCEND_L;

  frame_down_counter #(.W(8)) u_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .i_en      (startOfFrame && w_descending),
    .i_load    (w_load),
    .i_load_val(8'(DESCEND_FRAMES)),
    .o_done    (w_done)
  );

  // HALT only listens to restart; every other move waits for a frame tick
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (r_state == HALT) begin
      if (restart) w_state_nxt = MARCH_R;
    end else if (startOfFrame) begin
      if (reachedBottom) w_state_nxt = HALT;
      else if (r_state == MARCH_R && hitRight) begin
        w_state_nxt = DESCEND_R;
        w_load      = 1'b1;
      end else if (r_state == MARCH_L && hitLeft) begin
        w_state_nxt = DESCEND_L;
        w_load      = 1'b1;
      end else if (r_state == DESCEND_R && w_done) w_state_nxt = MARCH_L;
      else if (r_state == DESCEND_L && w_done) w_state_nxt = MARCH_R;
    end
  end

`ifdef INVADER_CTRL_SPEEDUP_EN
  logic [10:0] w_sum;
  assign w_sum     = {1'b0, r_mag} + 11'(SPEED_STEP);
  assign w_mag_nxt = (r_state == HALT) ? (restart ? 10'(INITIAL_X_SPEED) : r_mag)
                   : speedUp ? (w_sum > 11'(MAX_SPEED) ? 10'(MAX_SPEED) : w_sum[9:0])
                   : r_mag;
`else
  assign w_mag_nxt = 10'(INITIAL_X_SPEED);
`endif

  assign w_mag_ext = SPEED_W'(w_mag_nxt);
  assign w_x_nxt   = (w_state_nxt == MARCH_R) ? w_mag_ext
                   : (w_state_nxt == MARCH_L) ? -w_mag_ext : '0;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state  <= MARCH_R;
      r_mag    <= 10'(INITIAL_X_SPEED);
      xSpeed   <= SPEED_W'(INITIAL_X_SPEED);
      ySpeed   <= '0;
      chgDir   <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mag    <= w_mag_nxt;
      xSpeed   <= w_x_nxt;
      ySpeed   <= (w_state_nxt == DESCEND_R || w_state_nxt == DESCEND_L) ? SPEED_W'(Y_DESCEND_SPEED) : '0;
      chgDir   <= w_load;
      gameOver <= w_state_nxt == HALT;
    end

  assign marchState = r_state;
endmodule

// File: tb/tb_invader_march_ctrl.sv
// tb_invader_march_ctrl: directed stimulus with a queued-expectation scoreboard for invader_march_ctrl.
module tb_invader_march_ctrl;
`ifdef INVADER_CTRL_SPEEDUP_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam logic [6:0] RST  = 7'b0_000000;
  localparam logic [6:0] IDLE = 7'b1_000000;
  localparam logic [6:0] SOF  = 7'b1_100000;
  localparam logic [6:0] HL   = 7'b0_010000;
  localparam logic [6:0] HR   = 7'b0_001000;
  localparam logic [6:0] RB   = 7'b0_000100;
  localparam logic [6:0] SU   = 7'b0_000010;
  localparam logic [6:0] RS   = 7'b0_000001;
  localparam logic [2:0] MR = 3'd0, DR = 3'd1, ML = 3'd2, DL = 3'd3, HT = 3'd4;

  logic clk = 1'b0, resetN = 1'b0;
  logic sof = 1'b0, hl = 1'b0, hr = 1'b0, rb = 1'b0, su = 1'b0, rs = 1'b0;
  logic signed [10:0] xs, ys;
  logic cd, go;
  logic [2:0] ms;
  int errors = 0, checks = 0;

  typedef struct {
    int         x;
    int         y;
    logic       c;
    logic       g;
    logic [2:0] s;
    bit         cc;
    string      n;
  } exp_t;
  exp_t q[$];

  invader_march_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .hitLeft(hl), .hitRight(hr),
    .reachedBottom(rb), .speedUp(su), .restart(rs), .xSpeed(xs), .ySpeed(ys),
    .chgDir(cd), .gameOver(go), .marchState(ms)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [6:0] in, input int ex, input int ey, input logic ec,
                      input logic eg, input logic [2:0] es, input string n, input bit cc = 1'b0);
    @(negedge clk);
    {resetN, sof, hl, hr, rb, su, rs} = in;
    q.push_back('{ex, ey, ec, eg, es, cc, n});
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (int'(xs) != e.x || int'(ys) != e.y || cd !== e.c || go !== e.g || ms !== e.s ||
          (e.cc && dut.u_cnt.r_cnt !== 8'd0)) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d chg=%b go=%b st=%0d cnt=%0d, want x=%0d y=%0d chg=%b go=%b st=%0d%s",
                 e.n, xs, ys, cd, go, ms, dut.u_cnt.r_cnt, e.x, e.y, e.c, e.g, e.s, e.cc ? " cnt=0" : "");
      end
    end
  end

  initial begin
    int m;
    step(RST, 30, 0, 0, 0, MR, "reset");
    step(RST, 30, 0, 0, 0, MR, "reset_cnt", 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(SOF, 30, 0, 0, 0, MR, "march_r");
      step(IDLE, 30, 0, 0, 0, MR, "march_r_idle");
    end
    step(SOF | HL, 30, 0, 0, 0, MR, "hitl_in_mr_ignored");
    step(SOF | HR, 0, 48, 1, 0, DR, "enter_desc_r");
    step(IDLE | SU, 0, 48, 0, 0, DR, "speedup_in_desc");
    m = EN ? 34 : 30;
    for (int i = 0; i < 7; i++) begin
      step(SOF, 0, 48, 0, 0, DR, "desc_r_tick");
      step(IDLE, 0, 48, 0, 0, DR, "desc_r_idle");
    end
    step(SOF, -m, 0, 0, 0, ML, "desc_r_to_ml");
    step(SOF | HR, -m, 0, 0, 0, ML, "hitr_in_ml_ignored");
    step(SOF | HL | HR, 0, 48, 1, 0, DL, "dual_hit_desc_l");
    for (int i = 0; i < 7; i++) step(SOF, 0, 48, 0, 0, DL, "desc_l_tick");
    step(SOF, m, 0, 0, 0, MR, "desc_l_to_mr");
    for (int k = 0; k < 30; k++) begin
      m = EN ? ((m + 4 > 120) ? 120 : m + 4) : 30;
      step(IDLE | SU, m, 0, 0, 0, MR, "speedup_sat");
    end
    step(SOF | RB | HR, 0, 0, 0, 1, HT, "bottom_beats_hitr");
    step(IDLE | SU, 0, 0, 0, 1, HT, "speedup_in_halt");
    step(SOF, 0, 0, 0, 1, HT, "halt_hold");
    step(IDLE | RS, 30, 0, 0, 0, MR, "restart");
    m = EN ? 34 : 30;
    step(IDLE | SU, m, 0, 0, 0, MR, "speedup_after_restart");
    step(IDLE | RS, m, 0, 0, 0, MR, "restart_outside_halt");
    step(SOF | HR, 0, 48, 1, 0, DR, "enter_desc_r2");
    for (int i = 0; i < 3; i++) step(SOF, 0, 48, 0, 0, DR, "desc_r2_tick");
    step(RST, 30, 0, 0, 0, MR, "reset_mid_desc", 1'b1);
    step(IDLE, 30, 0, 0, 0, MR, "post_reset");
    for (int i = 0; i < 3; i++) step(SOF, 30, 0, 0, 0, MR, "no_resume_desc");
    step(IDLE | SU, EN ? 34 : 30, 0, 0, 0, MR, "speedup_macro");
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
